// File: rtl/sv_stream_classifier.sv
// Linear-kernel SV stream classifier: accumulates BIAS + sum(y*alpha*x_sv*x_test) over NUM_SV tuples.
// Optional SVC_ACC_SAT_EN makes every add/sub saturate instead of wrapping.
module sv_stream_classifier #(
  parameter int NUM_SV = 50,
  parameter int ACC_W  = 32,
  parameter logic signed [ACC_W-1:0] BIAS = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       x_test,
  input  logic             sv_valid,
  output logic             sv_ready,
  input  logic [8:0]       alpha_in,
  input  logic [8:0]       xsv_in,
  input  logic [1:0]       ysv_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       label,
  output logic [ACC_W-1:0] score,
  output logic [1:0]       dbg_state
);

  // sv_valid/sv_ready: a tuple is consumed on a rising edge where both are high;
  // sv_ready is high for the whole ACCUM state, and the source may stall freely.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [8:0]              x_test_q;
  logic [6:0]              count_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] score_q;
  logic [1:0]              label_q;
  logic [1:0]              label_d;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic [17:0]             k;
  logic [26:0]             t;
  logic [ACC_W-1:0]        t_ext;
  logic                    accept;
  logic                    last;

  assign k      = xsv_in * x_test_q;
  assign t      = alpha_in * k;
  assign t_ext  = {{(ACC_W-27){1'b0}}, t};
  assign accept = sv_valid && ready_q;
  assign last   = (count_q == 7'(NUM_SV - 1));

`ifdef SVC_ACC_SAT_EN
  // One extra bit catches overflow; clamp to the nearest representable extreme.
  logic signed [ACC_W:0] wide;
  always_comb begin
    wide  = {acc_q[ACC_W-1], acc_q};
    acc_d = acc_q;
    case (ysv_in)
      2'b01:   wide = {acc_q[ACC_W-1], acc_q} + {1'b0, t_ext};
      2'b11:   wide = {acc_q[ACC_W-1], acc_q} - {1'b0, t_ext};
      default: wide = {acc_q[ACC_W-1], acc_q};
    endcase
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_d = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_d = wide[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    acc_d = acc_q;
    case (ysv_in)
      2'b01:   acc_d = acc_q + t_ext;
      2'b11:   acc_d = acc_q - t_ext;
      default: acc_d = acc_q;
    endcase
  end
`endif

  // Zero score counts as the positive class.
  assign label_d = acc_d[ACC_W-1] ? 2'b11 : 2'b01;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_test_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      score_q  <= '0;
      label_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_test_q <= x_test;
            acc_q    <= BIAS;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_q + 7'd1;
            if (last) begin
              score_q <= acc_d;
              label_q <= label_d;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sv_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign label     = label_q;
  assign score     = score_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sv_stream_classifier.sv
// Bench for sv_stream_classifier: four configurations checked against an integer reference model.
// Honours SVC_ACC_SAT_EN in the model so either build can be checked.
module tb_sv_stream_classifier;

`ifdef SVC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] start_v = '0;
  logic [8:0] x_test = '0;
  logic       sv_valid = 1'b0;
  logic [8:0] alpha_in = '0;
  logic [8:0] xsv_in = '0;
  logic [1:0] ysv_in = '0;

  // A: NUM_SV=3 ACC_W=29 BIAS=0, B: NUM_SV=2 BIAS=5, C: NUM_SV=2 BIAS=10, D: defaults
  logic a_ready, a_busy, a_done, b_ready, b_busy, b_done;
  logic c_ready, c_busy, c_done, d_ready, d_busy, d_done;
  logic [1:0] a_label, b_label, c_label, d_label;
  logic [1:0] a_st, b_st, c_st, d_st;
  logic [28:0] a_score;
  logic [31:0] b_score, c_score, d_score;

  sv_stream_classifier #(.NUM_SV(3), .ACC_W(29), .BIAS(29'sd0)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .x_test(x_test), .sv_valid(sv_valid),
    .sv_ready(a_ready), .alpha_in(alpha_in), .xsv_in(xsv_in), .ysv_in(ysv_in),
    .busy(a_busy), .done(a_done), .label(a_label), .score(a_score), .dbg_state(a_st));
  sv_stream_classifier #(.NUM_SV(2), .ACC_W(32), .BIAS(32'sd5)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .x_test(x_test), .sv_valid(sv_valid),
    .sv_ready(b_ready), .alpha_in(alpha_in), .xsv_in(xsv_in), .ysv_in(ysv_in),
    .busy(b_busy), .done(b_done), .label(b_label), .score(b_score), .dbg_state(b_st));
  sv_stream_classifier #(.NUM_SV(2), .ACC_W(32), .BIAS(32'sd10)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .x_test(x_test), .sv_valid(sv_valid),
    .sv_ready(c_ready), .alpha_in(alpha_in), .xsv_in(xsv_in), .ysv_in(ysv_in),
    .busy(c_busy), .done(c_done), .label(c_label), .score(c_score), .dbg_state(c_st));
  sv_stream_classifier u_d (
    .clk(clk), .reset(reset), .start(start_v[3]), .x_test(x_test), .sv_valid(sv_valid),
    .sv_ready(d_ready), .alpha_in(alpha_in), .xsv_in(xsv_in), .ysv_in(ysv_in),
    .busy(d_busy), .done(d_done), .label(d_label), .score(d_score), .dbg_state(d_st));

  // View of the instance under test
  int sel = 0;
  logic m_ready, m_busy, m_done;
  logic [1:0] m_label;
  logic [31:0] m_score;
  always_comb begin
    m_ready = a_ready; m_busy = a_busy; m_done = a_done; m_label = a_label;
    m_score = {{3{a_score[28]}}, a_score};
    case (sel)
      1: begin m_ready = b_ready; m_busy = b_busy; m_done = b_done; m_label = b_label; m_score = b_score; end
      2: begin m_ready = c_ready; m_busy = c_busy; m_done = c_done; m_label = c_label; m_score = c_score; end
      3: begin m_ready = d_ready; m_busy = d_busy; m_done = d_done; m_label = d_label; m_score = d_score; end
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] ta[0:63];
  logic [8:0] tx[0:63];
  logic [1:0] ty[0:63];
  int         tg[0:63];
  logic [31:0] exp_q[$];
  logic [31:0] prev_score[0:3];
  logic [1:0]  prev_label[0:3];

  function automatic int nsv_of(input int inst);
    return (inst == 0) ? 3 : (inst == 3) ? 50 : 2;
  endfunction
  function automatic int accw_of(input int inst);
    return (inst == 0) ? 29 : 32;
  endfunction
  function automatic longint bias_of(input int inst);
    return (inst == 1) ? 64'sd5 : (inst == 2) ? 64'sd10 : 64'sd0;
  endfunction

  // Reference: plain integer dot product, wrapped or clamped to ACC_W after each step
  function automatic longint ref_score(input int inst, input int xt);
    longint acc, t, hi, lo, m;
    int w;
    w   = accw_of(inst);
    hi  = (64'sd1 <<< (w - 1)) - 1;
    lo  = -(64'sd1 <<< (w - 1));
    m   = 64'sd1 <<< w;
    acc = bias_of(inst);
    for (int i = 0; i < nsv_of(inst); i++) begin
      t = longint'(ta[i]) * longint'(tx[i]) * longint'(xt);
      if (ty[i] == 2'b01) acc = acc + t;
      else if (ty[i] == 2'b11) acc = acc - t;
      if (SAT) begin
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end else begin
        acc = acc & (m - 1);
        if (acc > hi) acc = acc - m;
      end
    end
    return acc;
  endfunction

  // ---------------- driver ----------------
  task automatic run_class(input int inst, input int xt, input bit poke_start);
    longint exp_s;
    logic [31:0] exp_w;
    logic [1:0]  exp_l;
    int edges, gsum, guard;
    bit got;
    sel   = inst;
    exp_s = ref_score(inst, xt);
    exp_w = 32'(exp_s);
    exp_l = (exp_s >= 0) ? 2'b01 : 2'b11;
    exp_q.push_back(exp_w);
    @(negedge clk);
    x_test = 9'(xt);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1 start_v = '0;
    edges = 0; gsum = 0;
    for (int i = 0; i < nsv_of(inst); i++) begin
      sv_valid = 1'b0;
      for (int g = 0; g < tg[i]; g++) begin
        if (poke_start) start_v[inst] = 1'b1;
        @(posedge clk); edges++;
        #1 start_v = '0;
      end
      gsum += tg[i];
      sv_valid = 1'b1; alpha_in = ta[i]; xsv_in = tx[i]; ysv_in = ty[i];
      got = 1'b0; guard = 0;
      while (!got && guard < 20) begin
        @(negedge clk);
        got = m_ready;
        if (i == 0 && guard == 0) begin
          n_cmp++;
          if (m_busy !== 1'b1 || m_score !== prev_score[inst] || m_label !== prev_label[inst]) begin
            n_err++;
            $display("FAIL hold_inst%0d: busy=%b score=%0d label=%b, required busy=1 score=%0d label=%b",
                     inst, m_busy, $signed(m_score), m_label, 1'b1, $signed(prev_score[inst]), prev_label[inst]);
          end
        end
        @(posedge clk); edges++;
        #1 guard++;
      end
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout_inst%0d: tuple %0d not accepted within 20 cycles", inst, i);
      end
    end
    sv_valid = 1'b0;
    n_cmp++;
    if (edges !== nsv_of(inst) + gsum) begin
      n_err++;
      $display("FAIL latency_inst%0d: edges=%0d, required %0d", inst, edges, nsv_of(inst) + gsum);
    end
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_cmp++;
    if (m_done !== 1'b1 || m_score !== exp_w || m_label !== exp_l || m_busy !== 1'b0 || m_ready !== 1'b0) begin
      n_err++;
      $display("FAIL result_inst%0d: done=%b busy=%b ready=%b score=%0d label=%b, required done=1 busy=0 ready=0 score=%0d label=%b",
               inst, m_done, m_busy, m_ready, $signed(m_score), m_label, $signed(exp_w), exp_l);
    end
    @(negedge clk);
    n_cmp++;
    if (m_done !== 1'b0 || m_score !== exp_w || m_label !== exp_l) begin
      n_err++;
      $display("FAIL done_width_inst%0d: done=%b score=%0d label=%b, required done=0 score=%0d label=%b",
               inst, m_done, $signed(m_score), m_label, $signed(exp_w), exp_l);
    end
    prev_score[inst] = exp_w;
    prev_label[inst] = exp_l;
  endtask

  task automatic load_test2();
    ta[0] = 9'd3; tx[0] = 9'd4; ty[0] = 2'b01; tg[0] = 0;
    ta[1] = 9'd1; tx[1] = 9'd5; ty[1] = 2'b11; tg[1] = 0;
    ta[2] = 9'd2; tx[2] = 9'd1; ty[2] = 2'b00; tg[2] = 0;
  endtask

  task automatic clear_prev();
    for (int i = 0; i < 4; i++) begin prev_score[i] = '0; prev_label[i] = '0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 0;
    #1;
    n_cmp++;
    if (m_ready !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_label !== 2'b00 || m_score !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b label=%b score=%0d, required all zero",
               m_ready, m_busy, m_done, m_label, $signed(m_score));
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    clear_prev();
    // A finished run leaves nonzero outputs; an async reset mid-cycle must clear them at once
    load_test2();
    run_class(0, 2, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (m_ready !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_label !== 2'b00 || m_score !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: ready=%b busy=%b done=%b label=%b score=%0d, required all zero",
               m_ready, m_busy, m_done, m_label, $signed(m_score));
    end
    #3 reset = 1'b0;
    clear_prev();
  endtask

  task automatic test_basic();
    load_test2();
    run_class(0, 2, 1'b0);
  endtask

  task automatic test_bias();
    ta[0] = 9'd1; tx[0] = 9'd10; ty[0] = 2'b11; tg[0] = 0;
    ta[1] = 9'd1; tx[1] = 9'd0;  ty[1] = 2'b01; tg[1] = 0;
    run_class(1, 1, 1'b0);
    run_class(2, 1, 1'b0);
  endtask

  task automatic test_stall_restart();
    load_test2();
    tg[1] = 2;
    run_class(0, 2, 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin ta[i] = 9'd511; tx[i] = 9'd511; ty[i] = 2'b01; tg[i] = 0; end
    run_class(0, 511, 1'b0);
    for (int i = 0; i < 3; i++) ty[i] = 2'b11;
    run_class(0, 511, 1'b0);
  endtask

  task automatic test_reset_mid_accum();
    sel = 0;
    load_test2();
    @(negedge clk);
    x_test = 9'd7; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v = '0;
    sv_valid = 1'b1; alpha_in = 9'd100; xsv_in = 9'd200; ysv_in = 2'b01;
    @(posedge clk);
    #2 sv_valid = 1'b0; reset = 1'b1;
    #1;
    n_cmp++;
    if (m_busy !== 1'b0 || m_ready !== 1'b0 || m_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_accum: busy=%b ready=%b done=%b, required 0 0 0", m_busy, m_ready, m_done);
    end
    #3 reset = 1'b0;
    clear_prev();
    run_class(0, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int inst;
      inst = (r % 2 == 0) ? 0 : 3;
      for (int i = 0; i < 64; i++) begin
        ta[i] = 9'($urandom_range(0, 511));
        tx[i] = 9'($urandom_range(0, 511));
        ty[i] = 2'($urandom_range(0, 3));
        tg[i] = $urandom_range(0, 2);
      end
      run_class(inst, $urandom_range(0, 511), r[0]);
    end
  endtask

  task automatic test_back_to_back();
    load_test2();
    run_class(0, 2, 1'b0);
    ty[0] = 2'b11; ty[1] = 2'b01; ty[2] = 2'b10;
    run_class(0, 2, 1'b0);
  endtask

  initial begin
    clear_prev();
    test_reset();
    test_basic();
    test_bias();
    test_stall_restart();
    test_overflow();
    test_reset_mid_accum();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
